// File: rtl/vga_pkg.sv
// Shared 640x480 timing defaults, widths and sync-tracker state encoding
// for the VGA sink-side frame receiver.
package vga_pkg;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned RGB_W     = 12;
    localparam int unsigned KEY_CNT_W = 19;

    localparam int unsigned VGA_H_VISIBLE   = 640;
    localparam int unsigned VGA_H_TOTAL     = 800;
    localparam int unsigned VGA_H_START     = 144;
    localparam int unsigned VGA_V_VISIBLE   = 480;
    localparam int unsigned VGA_V_TOTAL     = 525;
    localparam int unsigned VGA_V_START     = 35;
    localparam int unsigned VGA_LOCK_FRAMES = 2;

    localparam logic [RGB_W-1:0] VGA_KEY_COLOR = 12'hF00;
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

endpackage

// File: rtl/vga_sync_tracker.sv
// Rebuilds h/v position from HS/VS falling edges, checks line and frame
// lengths and runs the SEARCH/TRAIN/LOCKED lock state machine.
module vga_sync_tracker
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned H_START     = VGA_H_START,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned V_START     = VGA_V_START,
    parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             hs,
    input  logic             vs,
    output logic             locked,
    output logic             sample_ok_c,
    output logic             visible_c,
    output logic             bound_c,
    output logic             frame_c,
    output logic             err_c,
    output logic [CNT_W-1:0] x_c,
    output logic [CNT_W-1:0] y_c
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_START + H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_START + V_VISIBLE - 1);
    localparam int unsigned      GOOD_W  = $clog2(LOCK_FRAMES + 1);

    sync_state_e       state, state_nxt;
    logic [GOOD_W-1:0] good, good_nxt;
    logic              dirty, dirty_nxt;

    logic             hs_prev, vs_prev, vs_pend, vs_pend_nxt;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic             hs_fall, vs_fall, any_err;

    // Edge detection, counters and length checks. A VS fall coinciding with
    // the HS fall starts the new frame on that same line.
    always_comb begin
        hs_fall     = pix_en & hs_prev & ~hs;
        vs_fall     = pix_en & vs_prev & ~vs;
        bound_c     = hs_fall & (vs_pend | vs_fall);
        any_err     = (pix_en & (hs_fall ? (h_cnt != H_LAST) : (h_cnt == H_LAST)))
                    | (bound_c & (v_cnt != V_LAST));
        vs_pend_nxt = vs_pend;
        if (bound_c) begin
            vs_pend_nxt = 1'b0;
        end else if (vs_fall) begin
            vs_pend_nxt = 1'b1;
        end
        h_nxt = h_cnt;
        if (hs_fall) begin
            h_nxt = '0;
        end else if (pix_en && h_cnt != CNT_MAX) begin
            h_nxt = h_cnt + CNT_W'(1);
        end
        v_nxt = v_cnt;
        if (bound_c) begin
            v_nxt = '0;
        end else if (hs_fall && v_cnt != CNT_MAX) begin
            v_nxt = v_cnt + CNT_W'(1);
        end
        // The sampled pixel is labelled with the post-update position.
        visible_c = (h_nxt >= H_FIRST) && (h_nxt <= H_END)
                 && (v_nxt >= V_FIRST) && (v_nxt <= V_END);
        x_c = h_nxt - H_FIRST;
        y_c = v_nxt - V_FIRST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            vs_pend <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            if (pix_en) begin
                hs_prev <= hs;
                vs_prev <= vs;
            end
            vs_pend <= vs_pend_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEARCH;
            good   <= '0;
            dirty  <= 1'b0;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            good   <= good_nxt;
            dirty  <= dirty_nxt;
            locked <= (state_nxt == LOCKED);
        end
    end

    // Lock FSM; dirty remembers an error since the last frame boundary.
    always_comb begin
        state_nxt   = state;
        good_nxt    = good;
        dirty_nxt   = dirty;
        err_c       = 1'b0;
        frame_c     = 1'b0;
        sample_ok_c = 1'b0;
        case (state)
            SEARCH: begin
                if (bound_c) begin
                    state_nxt = TRAIN;
                    good_nxt  = '0;
                    dirty_nxt = 1'b0;
                end
            end
            TRAIN: begin
                if (any_err) begin
                    err_c     = 1'b1;
                    good_nxt  = '0;
                    dirty_nxt = ~bound_c;
                end else if (bound_c) begin
                    dirty_nxt = 1'b0;
                    if (!dirty) begin
                        good_nxt = good + GOOD_W'(1);
                        if (good == GOOD_W'(LOCK_FRAMES - 1)) begin
                            state_nxt = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    err_c     = 1'b1;
                    state_nxt = SEARCH;
                end else begin
                    sample_ok_c = pix_en;
                    frame_c     = bound_c;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA sink: locks to HS/VS timing, reports pixel position/data and measures
// the key-colour bounding box and pixel count of every locked frame.
module vga_frame_receiver
    import vga_pkg::*;
#(
    parameter int unsigned      H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned      H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned      H_START     = VGA_H_START,
    parameter int unsigned      V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned      V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned      V_START     = VGA_V_START,
    parameter int unsigned      LOCK_FRAMES = VGA_LOCK_FRAMES,
    parameter logic [RGB_W-1:0] KEY_COLOR   = VGA_KEY_COLOR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic                 HS,
    input  logic                 VS,
    input  logic [RGB_W-1:0]     vgaRGB,
    output logic                 locked,
    output logic                 de,
    output logic [CNT_W-1:0]     px_x,
    output logic [CNT_W-1:0]     px_y,
    output logic [RGB_W-1:0]     px_rgb,
    output logic                 frame_done,
    output logic [KEY_CNT_W-1:0] key_count,
    output logic                 bbox_valid,
    output logic [CNT_W-1:0]     bbox_xmin,
    output logic [CNT_W-1:0]     bbox_xmax,
    output logic [CNT_W-1:0]     bbox_ymin,
    output logic [CNT_W-1:0]     bbox_ymax,
    output logic                 timing_err
);

    logic             sample_ok_c, visible_c, bound_c, frame_c, err_c, key_hit_c;
    logic [CNT_W-1:0] x_c, y_c;

    logic [KEY_CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0]     acc_xmin, acc_xmax, acc_ymin, acc_ymax;

    vga_sync_tracker #(
        .H_VISIBLE   (H_VISIBLE),
        .H_TOTAL     (H_TOTAL),
        .H_START     (H_START),
        .V_VISIBLE   (V_VISIBLE),
        .V_TOTAL     (V_TOTAL),
        .V_START     (V_START),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hs          (HS),
        .vs          (VS),
        .locked      (locked),
        .sample_ok_c (sample_ok_c),
        .visible_c   (visible_c),
        .bound_c     (bound_c),
        .frame_c     (frame_c),
        .err_c       (err_c),
        .x_c         (x_c),
        .y_c         (y_c)
    );

    assign key_hit_c = sample_ok_c & visible_c & (vgaRGB == KEY_COLOR);

    // Pixel outputs hold between pix_en samples; strobes last one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            de         <= 1'b0;
            px_x       <= '0;
            px_y       <= '0;
            px_rgb     <= '0;
            frame_done <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            frame_done <= pix_en & frame_c;
            timing_err <= pix_en & err_c;
            if (pix_en) begin
                de     <= sample_ok_c & visible_c;
                px_x   <= x_c;
                px_y   <= y_c;
                px_rgb <= vgaRGB;
            end
        end
    end

    // Key accumulators restart at every boundary; the boundary pixel itself
    // belongs to the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt    <= '0;
            acc_xmin   <= CNT_MAX;
            acc_xmax   <= '0;
            acc_ymin   <= CNT_MAX;
            acc_ymax   <= '0;
            key_count  <= '0;
            bbox_valid <= 1'b0;
            bbox_xmin  <= CNT_MAX;
            bbox_xmax  <= '0;
            bbox_ymin  <= CNT_MAX;
            bbox_ymax  <= '0;
        end else begin
            if (pix_en && frame_c) begin
                key_count  <= acc_cnt;
                bbox_valid <= (acc_cnt != '0);
                bbox_xmin  <= acc_xmin;
                bbox_xmax  <= acc_xmax;
                bbox_ymin  <= acc_ymin;
                bbox_ymax  <= acc_ymax;
            end
            if (bound_c) begin
                acc_cnt  <= key_hit_c ? KEY_CNT_W'(1) : '0;
                acc_xmin <= key_hit_c ? x_c : CNT_MAX;
                acc_xmax <= key_hit_c ? x_c : '0;
                acc_ymin <= key_hit_c ? y_c : CNT_MAX;
                acc_ymax <= key_hit_c ? y_c : '0;
            end else if (key_hit_c) begin
                acc_cnt <= acc_cnt + KEY_CNT_W'(1);
                if (x_c < acc_xmin) acc_xmin <= x_c;
                if (x_c > acc_xmax) acc_xmax <= x_c;
                if (y_c < acc_ymin) acc_ymin <= y_c;
                if (y_c > acc_ymax) acc_ymax <= y_c;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Directed bench for vga_frame_receiver on a scaled-down timing
// (32x16 total, 24x12 visible) so that many frames fit in a short run.
module tb_vga_frame_receiver;

    localparam int HV = 24, HT = 32, HST = 6, HSYNC = 4;
    localparam int VV = 12, VT = 16, VST = 3, VSYNC = 2;

    logic        clk, rst, pix_en, HS, VS;
    logic [11:0] vgaRGB;
    logic        locked, de, frame_done, bbox_valid, timing_err;
    logic [9:0]  px_x, px_y, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic [11:0] px_rgb;
    logic [18:0] key_count;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;
    int te_cnt   = 0;
    bit rand_gaps = 1'b0;

    vga_frame_receiver #(
        .H_VISIBLE (HV), .H_TOTAL (HT), .H_START (HST),
        .V_VISIBLE (VV), .V_TOTAL (VT), .V_START (VST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .HS         (HS),
        .VS         (VS),
        .vgaRGB     (vgaRGB),
        .locked     (locked),
        .de         (de),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_rgb     (px_rgb),
        .frame_done (frame_done),
        .key_count  (key_count),
        .bbox_valid (bbox_valid),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .timing_err (timing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (timing_err) te_cnt <= te_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] pix_color(input int mode, input int x, input int y);
        logic key;
        key = (mode == 1 && x >= 5 && x <= 8 && y >= 3 && y <= 6)
           || (mode == 2 && ((x == 0 && y == 0) || (x == HV-1 && y == VV-1)));
        return key ? 12'hF00 : {4'(x), 4'(y), 4'h5};
    endfunction

    // One pixel period: optional idle gap, then a single pix_en clk.
    task automatic pix(input logic h, input logic v, input logic [11:0] c);
        int gap;
        gap = rand_gaps ? int'($urandom_range(0, 7)) : 3;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        HS = h; VS = v; vgaRGB = c; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
    endtask

    task automatic send_frame(input int first_line, input int lines, input int short_line,
                              input int mode, input int exp_lock, input int exp_fd,
                              input int exp_err, input bit probe);
        for (int vp = first_line; vp < lines; vp++) begin
            int len;
            len = (vp == short_line) ? HT - 1 : HT;
            for (int hp = 0; hp < len; hp++) begin
                bit vis;
                vis = hp >= HST && hp < HST + HV && vp >= VST && vp < VST + VV;
                pix(hp >= HSYNC, vp >= VSYNC, vis ? pix_color(mode, hp - HST, vp - VST) : 12'h000);
                if (vp == first_line && hp == 0) begin
                    if (exp_lock >= 0) check("locked_at_start", locked, exp_lock);
                    if (exp_fd >= 0)   check("frame_done_at_start", frame_done, exp_fd);
                    if (exp_err >= 0)  check("timing_err_at_start", timing_err, exp_err);
                end
                if (short_line >= 0 && vp == short_line + 1 && hp == 0) begin
                    check("short_line_err", timing_err, 1);
                    check("short_line_unlock", locked, 0);
                end
                if (probe && vp == VST + 1 && hp == HST - 1) check("de_blank", de, 0);
                if (probe && vp == VST + 1 && hp == HST + 2) begin
                    check("de_vis", de, 1);
                    check("px_x", px_x, 2);
                    check("px_y", px_y, 1);
                    check("px_rgb", px_rgb, 12'h215);
                end
            end
        end
    endtask

    task automatic check_results(input int kc, input int vld, input int xmin, input int xmax,
                                 input int ymin, input int ymax);
        check("key_count", key_count, kc);
        check("bbox_valid", bbox_valid, vld);
        check("bbox_xmin", bbox_xmin, xmin);
        check("bbox_xmax", bbox_xmax, xmax);
        check("bbox_ymin", bbox_ymin, ymin);
        check("bbox_ymax", bbox_ymax, ymax);
    endtask

    task automatic check_reset();
        check("rst_locked", locked, 0);
        check("rst_de", de, 0);
        check("rst_px_x", px_x, 0);
        check("rst_px_y", px_y, 0);
        check("rst_px_rgb", px_rgb, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_timing_err", timing_err, 0);
        check_results(0, 0, 1023, 0, 1023, 0);
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; HS = 1'b1; VS = 1'b1; vgaRGB = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        repeat (4) pix(1'b1, 1'b1, 12'h000);

        // Lock acquisition: SEARCH -> TRAIN -> good 1 -> LOCKED at 3rd boundary
        send_frame(0, VT, -1, 1, 0, 0, 0, 1'b0);
        send_frame(0, VT, -1, 1, 0, 0, 0, 1'b0);
        send_frame(0, VT, -1, 1, 1, 0, 0, 1'b1);
        send_frame(0, VT, -1, 0, 1, 1, 0, 1'b0);
        check_results(16, 1, 5, 8, 3, 6);
        send_frame(0, VT, -1, 2, 1, 1, 0, 1'b0);
        check_results(0, 0, 1023, 0, 1023, 0);
        check("no_err_clean", te_cnt, 0);

        // Short line while locked, then relock
        send_frame(0, VT, 5, 1, 1, 1, 0, 1'b0);
        check_results(2, 1, 0, HV-1, 0, VV-1);
        check("err_cnt_short", te_cnt, 1);
        send_frame(0, VT, -1, 1, 0, 0, 0, 1'b0);
        check("no_fd_bad_frame", fd_cnt, 3);
        send_frame(0, VT, -1, 1, 0, 0, 0, 1'b0);
        send_frame(0, VT, -1, 1, 1, 0, 0, 1'b0);
        send_frame(0, VT - 1, -1, 0, 1, 1, 0, 1'b0);
        check_results(16, 1, 5, 8, 3, 6);
        check("fd_cnt_relock", fd_cnt, 4);

        // Short frame boundary error, then reset mid-frame
        send_frame(0, 8, -1, 1, 0, 0, 1, 1'b0);
        check("err_cnt_frame", te_cnt, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
        send_frame(8, VT, -1, 1, -1, -1, -1, 1'b0);

        // Ideal stream with random enable gaps
        rand_gaps = 1'b1;
        send_frame(0, VT, -1, 1, 0, 0, 0, 1'b0);
        send_frame(0, VT, -1, 1, 0, 0, 0, 1'b0);
        send_frame(0, VT, -1, 1, 1, 0, 0, 1'b0);
        send_frame(0, VT, -1, 0, 1, 1, 0, 1'b0);
        check_results(16, 1, 5, 8, 3, 6);
        check("err_cnt_gaps", te_cnt, 2);
        check("fd_cnt_gaps", fd_cnt, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
